// File: rtl/serial_divider16.sv
// -----------------------------------------------------------------------------
// serial_divider16
//
// Purpose:
//   16-bit restoring divider, one quotient bit per clock. A start request in
//   IDLE captures the operands; sixteen COMPUTE cycles later the quotient and
//   remainder are latched and DONE is shown for one cycle. A zero divisor
//   skips COMPUTE and goes straight to DONE with quotient = 16'hFFFF,
//   remainder = dividend and div_zero set.
//
// Optional feature:
//   SERIAL_DIVIDER16_SIGNED_EN - when defined, operands and results are two's
//   complement. The core divides magnitudes; the quotient is negated when the
//   operand signs differ (truncation toward zero) and the remainder carries
//   the dividend's sign. Latency is the same in both builds.
//
// Handshake:
//   start is sampled only in IDLE. The edge that sees start=1 in IDLE accepts
//   the request and captures dividend/divisor; start or operand changes at
//   any other time have no effect. busy is high for the whole COMPUTE phase,
//   done is a one-cycle strobe, and quotient/remainder/div_zero change only
//   on entry to DONE or on reset.
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-high reset
//   start      in   1   operation request, sampled in IDLE
//   dividend   in  16   numerator, captured on the accepting edge
//   divisor    in  16   denominator, captured on the accepting edge
//   quotient   out 16   registered result, holds between operations
//   remainder  out 16   registered result, holds between operations
//   busy       out  1   high while in COMPUTE
//   done       out  1   high for the single DONE cycle
//   div_zero   out  1   last accepted divisor was zero
//   state_dbg  out  2   current FSM state (0 IDLE, 1 COMPUTE, 2 DONE)
// -----------------------------------------------------------------------------
module serial_divider16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state, state_nxt;

    // dvd_sh starts as the dividend magnitude; each step shifts its MSB into
    // the partial remainder and shifts the new quotient bit in at the LSB, so
    // after sixteen steps it holds the quotient.
    logic [15:0] dvd_sh;
    logic [15:0] dvs_r;
    // The working remainder is 17 bits wide during a step, but between steps
    // it is always smaller than the divisor, so its top bit is never set and
    // only the low 16 bits are stored.
    logic [15:0] prem;
    logic [3:0]  cnt;

    logic [15:0] dvd_mag;
    logic [15:0] dvs_mag;
    logic [16:0] shifted;
    logic [16:0] trial;
    logic        q_bit;
    logic [15:0] rem_nxt;
    logic [15:0] quo_nxt;
    logic [15:0] q_fin;
    logic [15:0] r_fin;

`ifdef SERIAL_DIVIDER16_SIGNED_EN
    logic q_neg;
    logic r_neg;

    assign dvd_mag = dividend[15] ? (~dividend + 16'd1) : dividend;
    assign dvs_mag = divisor[15]  ? (~divisor + 16'd1)  : divisor;
    // -32768 has magnitude 16'h8000, which is still correct as an unsigned
    // magnitude, so -32768 / -1 produces 16'h8000 with no special case.
    assign q_fin   = q_neg ? (~quo_nxt + 16'd1) : quo_nxt;
    assign r_fin   = r_neg ? (~rem_nxt + 16'd1) : rem_nxt;
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign q_fin   = quo_nxt;
    assign r_fin   = rem_nxt;
`endif

    // One restoring step: bring in the next dividend bit, trial-subtract the
    // divisor at 17-bit width, and keep the difference only if it did not
    // borrow (bit 16 clear).
    assign shifted = {prem, dvd_sh[15]};
    assign trial   = shifted - {1'b0, dvs_r};
    assign q_bit   = ~trial[16];
    assign rem_nxt = q_bit ? trial[15:0] : shifted[15:0];
    assign quo_nxt = {dvd_sh[14:0], q_bit};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor == 16'd0) ? DONE : COMPUTE;
                end
            end
            COMPUTE: begin
                busy = 1'b1;
                if (cnt == 4'd15) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign state_dbg = state;

    // Datapath and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dvd_sh    <= 16'd0;
            dvs_r     <= 16'd0;
            prem      <= 16'd0;
            cnt       <= 4'd0;
            quotient  <= 16'd0;
            remainder <= 16'd0;
            div_zero  <= 1'b0;
`ifdef SERIAL_DIVIDER16_SIGNED_EN
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == 16'd0) begin
                            // Raw dividend, not its magnitude, in both builds.
                            quotient  <= 16'hFFFF;
                            remainder <= dividend;
                            div_zero  <= 1'b1;
                        end else begin
                            dvd_sh <= dvd_mag;
                            dvs_r  <= dvs_mag;
                            prem   <= 16'd0;
                            cnt    <= 4'd0;
`ifdef SERIAL_DIVIDER16_SIGNED_EN
                            q_neg  <= dividend[15] ^ divisor[15];
                            r_neg  <= dividend[15];
`endif
                        end
                    end
                end
                COMPUTE: begin
                    dvd_sh <= quo_nxt;
                    prem   <= rem_nxt;
                    cnt    <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        quotient  <= q_fin;
                        remainder <= r_fin;
                        div_zero  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_divider16.sv
// -----------------------------------------------------------------------------
// tb_serial_divider16
//
// Directed bench for serial_divider16: a table of operand/result records is
// run through the divider, followed by hand-written sequences for reset,
// abort, start/operand interference and start held high. Results are matched
// against an expected queue filled with hand-computed values.
// -----------------------------------------------------------------------------
module tb_serial_divider16;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [1:0]  state_dbg;

    always #5 clk = ~clk;

    serial_divider16 dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_bad    = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] q, input logic [15:0] r,
                           input logic dz);
        vec_t v;
        v.a = a; v.b = b; v.q = q; v.r = r; v.dz = dz;
        vecs.push_back(v);
    endtask

    // Wait (bounded) for done; returns the number of edges waited.
    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = 0;
        while (!done && cycles < 40) begin
            if (busy) busy_cnt++;
            tick();
            cycles++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    // Full operation from IDLE: accept, count busy/latency, check results,
    // check that done lasts one cycle and the FSM goes back to IDLE.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] q, input logic [15:0] r,
                          input logic dz);
        int          cycles;
        int          busy_cnt;
        logic [31:0] e;
        exp_q.push_back({q, r});
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_done(cycles, busy_cnt);
        // Zero divisor: done is already up straight after the accepting edge.
        chk("latency", cycles, (b == 16'd0) ? 32'd0 : 32'd16);
        chk("busy_cycles", busy_cnt, (b == 16'd0) ? 32'd0 : 32'd16);
        e = exp_q.pop_front();
        chk("quotient", {16'd0, quotient}, {16'd0, e[31:16]});
        chk("remainder", {16'd0, remainder}, {16'd0, e[15:0]});
        chk("div_zero", {31'd0, div_zero}, {31'd0, dz});
        tick();
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("back_to_idle", {30'd0, state_dbg}, {30'd0, S_IDLE});
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int   cycles;
        int   busy_cnt;
        logic seen_done;
        logic seen_busy;

`ifdef SERIAL_DIVIDER16_SIGNED_EN
        add_vec(16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0); // -7 / 2
        add_vec(16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0); // -32768 / -1
        add_vec(16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0); // -100 / 7
        add_vec(16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0); // 100 / -7
        add_vec(16'hFFF9, 16'hFFFE, 16'h0003, 16'hFFFF, 1'b0); // -7 / -2
        add_vec(16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0); // -32768 / 1
        add_vec(16'd100,  16'd7,    16'd14,   16'd2,    1'b0);
        add_vec(16'hFFFB, 16'h0000, 16'hFFFF, 16'hFFFB, 1'b1); // -5 / 0
`else
        add_vec(16'd100,  16'd7,    16'd14,   16'd2,    1'b0);
        add_vec(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0);
        add_vec(16'hFFFE, 16'hFFFF, 16'h0000, 16'hFFFE, 1'b0);
        add_vec(16'd5,    16'd0,    16'hFFFF, 16'd5,    1'b1);
        add_vec(16'd1000, 16'd1000, 16'd1,    16'd0,    1'b0);
        add_vec(16'd0,    16'd3,    16'd0,    16'd0,    1'b0);
        add_vec(16'hABCD, 16'h0010, 16'h0ABC, 16'h000D, 1'b0);
        add_vec(16'd12345,16'd123,  16'd100,  16'd45,   1'b0);
        add_vec(16'h8000, 16'd3,    16'h2AAA, 16'd2,    1'b0);
`endif

        // Reset state
        reset    = 1'b1;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 16'd0;
        repeat (3) tick();
        chk("rst_quotient", {16'd0, quotient}, 32'd0);
        chk("rst_remainder", {16'd0, remainder}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
        chk("rst_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
        reset = 1'b0;
        tick();

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);
        end

        // Reset in the middle of COMPUTE: 300 / 10 aborted after 8 steps
        dividend = 16'd300;
        divisor  = 16'd10;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        repeat (8) tick();
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_quotient", {16'd0, quotient}, 32'd0);
        chk("abort_remainder", {16'd0, remainder}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_div_zero", {31'd0, div_zero}, 32'd0);
        chk("abort_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
        tick();
        reset     = 1'b0;
        seen_done = 1'b0;
        seen_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) seen_done = 1'b1;
            if (busy) seen_busy = 1'b1;
        end
        chk("abort_no_done", {31'd0, seen_done}, 32'd0);
        chk("abort_no_busy", {31'd0, seen_busy}, 32'd0);
        run_op(16'd300, 16'd10, 16'd30, 16'd0, 1'b0);

        // Start and operand changes while COMPUTE runs are ignored; results
        // from 300 / 10 must hold until the new result lands.
        dividend = 16'd100;
        divisor  = 16'd7;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tick();
        tick();
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 16'd5;
        tick();
        chk("ignore_start_state", {30'd0, state_dbg}, {30'd0, S_COMPUTE});
        chk("hold_quotient", {16'd0, quotient}, 32'd30);
        chk("hold_remainder", {16'd0, remainder}, 32'd0);
        tick();
        start    = 1'b0;
        dividend = 16'hFFFF;
        divisor  = 16'd1;
        wait_done(cycles, busy_cnt);
        chk("ignore_latency", cycles, 32'd12);
        chk("ignore_quotient", {16'd0, quotient}, 32'd14);
        chk("ignore_remainder", {16'd0, remainder}, 32'd2);
        tick();
        tick();
        chk("ignore_no_restart", {30'd0, state_dbg}, {30'd0, S_IDLE});

        // Start held high: one IDLE cycle between back-to-back operations,
        // and start seen in DONE does not skip that IDLE cycle.
        dividend = 16'd20;
        divisor  = 16'd3;
        start    = 1'b1;
        tick();
        wait_done(cycles, busy_cnt);
        chk("held_latency", cycles, 32'd16);
        chk("held_quotient1", {16'd0, quotient}, 32'd6);
        chk("held_remainder1", {16'd0, remainder}, 32'd2);
        tick();
        chk("held_idle_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
        chk("held_idle_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("held_restart_state", {30'd0, state_dbg}, {30'd0, S_COMPUTE});
        chk("held_restart_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_done(cycles, busy_cnt);
        chk("held_quotient2", {16'd0, quotient}, 32'd6);
        chk("held_remainder2", {16'd0, remainder}, 32'd2);
        tick();

        // Zero divisor directly after a nonzero result clears back correctly
        run_op(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1);
        run_op(16'd9, 16'd4, 16'd2, 16'd1, 1'b0);

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
